// File: rtl/cla_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_bist_pkg                                                 |
// | Description : Shared types and helpers for the CLA adder self-test engine. |
// |               FSM state encoding, vector widths and the expected-result    |
// |               function used to check the adder under test.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cla_bist_pkg;

   // Operand width of the adder under test; the vector space is 2^(2W+1).
   localparam int W     = 4;
   // One stimulus vector is {A, B, cinput}.
   localparam int VEC_W = 2 * W + 1;
   // One response is {Cout, Sum}.
   localparam int RES_W = W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Expected {cout, sum} for a packed {A, B, cinput} vector.
   function automatic logic [RES_W-1:0] calc_expected(input logic [VEC_W-1:0] vec);
      logic [RES_W-1:0] a_ext;
      logic [RES_W-1:0] b_ext;
      logic [RES_W-1:0] c_ext;
      a_ext = {1'b0, vec[VEC_W-1 -: W]};
      b_ext = {1'b0, vec[W -: W]};
      c_ext = {{W{1'b0}}, vec[0]};
      return a_ext + b_ext + c_ext;
   endfunction

endpackage : cla_bist_pkg
`default_nettype wire

// File: rtl/cla_bist_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_bist_checker_if                                          |
// | Description : Stimulus/response bus between the self-test engine and the  |
// |               adder under test.                                            |
// |               master : self-test engine (drives A, B, cinput;              |
// |                        receives Sum, Cout)                                 |
// |               slave  : adder under test (the reverse)                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface cla_bist_checker_if;
   import cla_bist_pkg::*;

   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         cinput;
   logic [W-1:0] Sum;
   logic         Cout;

   modport master (output A, B, cinput, input Sum, Cout);
   modport slave  (input A, B, cinput, output Sum, Cout);

endinterface : cla_bist_checker_if
`default_nettype wire

// File: rtl/cla_bist_resp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_bist_resp_pipe                                           |
// | Description : Valid-tagged delay line of DEPTH stages carrying             |
// |               {vector, expected} alongside the adder response latency.     |
// |   clk       in   clock                                                     |
// |   rst_n     in   asynchronous active-low reset, clears all valid tags      |
// |   flush     in   drop every in-flight entry (stage 0 still loads in_*)     |
// |   in_valid  in   tag for the entry entering stage 0                        |
// |   in_data   in   entry entering stage 0                                    |
// |   out_valid out  tag of the last stage                                     |
// |   out_data  out  entry in the last stage                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cla_bist_resp_pipe #(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [DEPTH-1:0]             valid_q;
   logic [DEPTH-1:0]             valid_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q;
   logic [DEPTH-1:0][DATA_W-1:0] data_d;

   always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1] & ~flush;
         data_d[i]  = data_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule : cla_bist_resp_pipe
`default_nettype wire

// File: rtl/cla_bist_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_bist_checker                                             |
// | Description : Exhaustive self-test engine for the W-bit CLA adder. Walks   |
// |               every {A, B, cinput} vector, checks each {Cout, Sum} against |
// |               A+B+cinput, counts mismatches (saturating) and captures the  |
// |               first failing vector.                                        |
// |   clk              in   clock                                              |
// |   rst_n            in   asynchronous active-low reset                      |
// |   start            in   begin a run (honoured only in IDLE or DONE)        |
// |   adder            if   master side of the stimulus/response bus           |
// |   busy             out  run or drain in progress                           |
// |   done             out  run complete, results stable                       |
// |   pass             out  no mismatches seen (valid with done)               |
// |   err_count        out  saturating mismatch count                          |
// |   first_fail_vec   out  {A, B, cinput} of the first mismatch               |
// |   first_fail_valid out  first_fail_vec holds a captured vector             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cla_bist_checker
   import cla_bist_pkg::*;
#(
   parameter int RESP_LAT = 1,   // 1..4 edges from stimulus update to response sample
   parameter int ERR_W    = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   cla_bist_checker_if.master    adder,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [VEC_W-1:0]      first_fail_vec,
   output logic                  first_fail_valid
);

   localparam int               PIPE_W     = VEC_W + RES_W;
   localparam logic [VEC_W-1:0] VEC_LAST   = '1;
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;
   // DRAIN lasts RESP_LAT-1 cycles; the counter is loaded with one less
   // because the cycle that sees zero is itself a DRAIN cycle.
   localparam logic [1:0]       DRAIN_LOAD = (RESP_LAT > 1) ? 2'(RESP_LAT - 2) : 2'd0;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [1:0]         drain_q, drain_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [VEC_W-1:0]   ffvec_q, ffvec_d;
   logic               ffvalid_q, ffvalid_d;
   logic               pass_q, pass_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               start_accept;
   logic               pipe_in_valid;
   logic [PIPE_W-1:0]  pipe_in_data;
   logic               tail_valid;
   logic [PIPE_W-1:0]  tail_data;
   logic [VEC_W-1:0]   tail_vec;
   logic [RES_W-1:0]   tail_exp;
   logic [RES_W-1:0]   resp;

   // The pipe is fed with the vector about to be loaded, so its stage 0
   // shadows the stimulus register and the tail lines up with the response
   // RESP_LAT edges later.
   assign pipe_in_valid = (state_d == RUN);
   assign pipe_in_data  = {vec_d, calc_expected(vec_d)};

   cla_bist_resp_pipe #(
      .DEPTH  (RESP_LAT),
      .DATA_W (PIPE_W)
   ) u_resp_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (start_accept),
      .in_valid  (pipe_in_valid),
      .in_data   (pipe_in_data),
      .out_valid (tail_valid),
      .out_data  (tail_data)
   );

   assign tail_vec = tail_data[PIPE_W-1 -: VEC_W];
   assign tail_exp = tail_data[RES_W-1:0];
   assign resp     = {adder.Cout, adder.Sum};

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      drain_d      = drain_q;
      err_d        = err_q;
      ffvec_d      = ffvec_q;
      ffvalid_d    = ffvalid_q;
      pass_d       = pass_q;
      start_accept = 1'b0;

      // Response check; the tail is only ever valid during RUN/DRAIN.
      if (tail_valid && (resp != tail_exp)) begin
         if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
         end
         if (!ffvalid_q) begin
            ffvec_d   = tail_vec;
            ffvalid_d = 1'b1;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               start_accept = 1'b1;
               state_d      = RUN;
               vec_d        = '0;
               err_d        = '0;
               ffvec_d      = '0;
               ffvalid_d    = 1'b0;
               pass_d       = 1'b0;
            end
         end
         RUN: begin
            vec_d = vec_q + VEC_W'(1);
            if (vec_q == VEC_LAST) begin
               if (RESP_LAT == 1) begin
                  state_d = DONE;
                  pass_d  = (err_d == '0);
               end else begin
                  state_d = DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
         end
         DRAIN: begin
            if (drain_q == 2'd0) begin
               state_d = DONE;
               pass_d  = (err_d == '0);
            end else begin
               drain_d = drain_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         drain_q   <= 2'd0;
         err_q     <= '0;
         ffvec_q   <= '0;
         ffvalid_q <= 1'b0;
         pass_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         drain_q   <= drain_d;
         err_q     <= err_d;
         ffvec_q   <= ffvec_d;
         ffvalid_q <= ffvalid_d;
         pass_q    <= pass_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign adder.A          = vec_q[VEC_W-1 -: W];
   assign adder.B          = vec_q[W -: W];
   assign adder.cinput     = vec_q[0];
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffvec_q;
   assign first_fail_valid = ffvalid_q;

endmodule : cla_bist_checker
`default_nettype wire

// File: tb/tb_cla_bist_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cla_bist_checker                                          |
// | Description : Self-checking bench for cla_bist_checker. Three instances    |
// |               (RESP_LAT=1/ERR_W=10, RESP_LAT=1/ERR_W=8, RESP_LAT=2/ERR_W=10)|
// |               each drive a behavioural adder with optional injected faults |
// |               and an optional output register. Expected results come from |
// |               an arithmetic enumeration of all 512 vectors.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cla_bist_checker;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       start_s [NDUT];
   logic       busy_s  [NDUT];
   logic       done_s  [NDUT];
   logic       pass_s  [NDUT];
   logic       ffv_s   [NDUT];
   logic [9:0] err_s   [NDUT];
   logic [8:0] ffvec_s [NDUT];
   logic [8:0] stim_s  [NDUT];
   logic [7:0] err_b8;

   // Adder fault configuration per instance: kind 0 = golden,
   // 1 = result bit fbit stuck at fval, 2 = Cout inverted.
   int   fkind [NDUT];
   int   fbit  [NDUT];
   logic fval  [NDUT];
   logic regm  [NDUT];

   int checks = 0;
   int errors = 0;

   cla_bist_checker_if ifc [NDUT] ();

   cla_bist_checker #(.RESP_LAT(1), .ERR_W(10)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .adder(ifc[0]),
      .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
      .first_fail_vec(ffvec_s[0]), .first_fail_valid(ffv_s[0]));

   cla_bist_checker #(.RESP_LAT(1), .ERR_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .adder(ifc[1]),
      .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_b8),
      .first_fail_vec(ffvec_s[1]), .first_fail_valid(ffv_s[1]));
   assign err_s[1] = {2'b00, err_b8};

   cla_bist_checker #(.RESP_LAT(2), .ERR_W(10)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .adder(ifc[2]),
      .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err_s[2]),
      .first_fail_vec(ffvec_s[2]), .first_fail_valid(ffv_s[2]));

   function automatic logic [4:0] faulty_add(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input int kind, input int bitn,
                                             input logic val);
      logic [4:0] r;
      r = 5'(a) + 5'(b) + 5'(c);
      if (kind == 1) r[bitn] = val;
      else if (kind == 2) r[4] = ~r[4];
      return r;
   endfunction

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_adder
      logic [4:0] res_c;
      logic [4:0] res_r;
      always_comb res_c = faulty_add(ifc[gi].A, ifc[gi].B, ifc[gi].cinput,
                                     fkind[gi], fbit[gi], fval[gi]);
      always @(posedge clk) res_r <= res_c;
      assign ifc[gi].Sum  = regm[gi] ? res_r[3:0] : res_c[3:0];
      assign ifc[gi].Cout = regm[gi] ? res_r[4]   : res_c[4];
      assign stim_s[gi]   = {ifc[gi].A, ifc[gi].B, ifc[gi].cinput};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: enumerate all vectors, compare the response the checker will
   // see (lagged by one vector when a registered adder meets RESP_LAT=1)
   // against A+B+cin, and saturate the count to the counter width.
   task automatic model_run(input int kind, input int bitn, input logic val, input logic regd,
                            input int resp_lat, input int err_w,
                            output int cnt, output int first, output logic fvalid);
      int offset, raw, src, cap;
      logic [4:0] expv, seen;
      offset = (regd ? 1 : 0) - (resp_lat - 1);
      raw = 0; first = 0; fvalid = 1'b0;
      for (int k = 0; k < 512; k++) begin
         src  = (k - offset < 0) ? 0 : k - offset;
         expv = 5'((k >> 5) & 15) + 5'((k >> 1) & 15) + 5'(k & 1);
         seen = faulty_add(4'((src >> 5) & 15), 4'((src >> 1) & 15), 1'(src & 1), kind, bitn, val);
         if (seen != expv) begin
            raw++;
            if (!fvalid) begin first = k; fvalid = 1'b1; end
         end
      end
      cap = (1 << err_w) - 1;
      cnt = (raw > cap) ? cap : raw;
   endtask

   task automatic run_to_done(input int idx, input int limit, output int edges);
      start_s[idx] = 1'b1;
      @(posedge clk); #1;
      start_s[idx] = 1'b0;
      edges = 1;
      while (done_s[idx] !== 1'b1 && edges < limit) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic run_and_verify(input int idx, input string name, input int exp_edges,
                                 input int resp_lat, input int err_w);
      int edges, cnt, first;
      logic fvalid;
      run_to_done(idx, exp_edges + 40, edges);
      model_run(fkind[idx], fbit[idx], fval[idx], regm[idx], resp_lat, err_w, cnt, first, fvalid);
      check({name, ":latency"}, edges, exp_edges);
      check({name, ":done"},    32'(done_s[idx]), 1);
      check({name, ":busy"},    32'(busy_s[idx]), 0);
      check({name, ":pass"},    32'(pass_s[idx]), (cnt == 0) ? 1 : 0);
      check({name, ":err"},     32'(err_s[idx]), cnt);
      check({name, ":ffvalid"}, 32'(ffv_s[idx]), 32'(fvalid));
      check({name, ":ffvec"},   32'(ffvec_s[idx]), fvalid ? first : 0);
   endtask

   task automatic check_reset_vals(input int idx, input string name);
      check({name, ":busy"},  32'(busy_s[idx]), 0);
      check({name, ":done"},  32'(done_s[idx]), 0);
      check({name, ":pass"},  32'(pass_s[idx]), 0);
      check({name, ":err"},   32'(err_s[idx]), 0);
      check({name, ":ffv"},   32'(ffv_s[idx]), 0);
      check({name, ":ffvec"}, 32'(ffvec_s[idx]), 0);
      check({name, ":stim"},  32'(stim_s[idx]), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hold, saved_err, partial;
      logic [9:0] s;
      rst_n = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         start_s[i] = 1'b0; fkind[i] = 0; fbit[i] = 0; fval[i] = 1'b0; regm[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals(0, "rst0");
      check_reset_vals(1, "rst1");
      check_reset_vals(2, "rst2");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Golden adder: full pass, 513 edges start-to-done.
      run_and_verify(0, "golden", 513, 1, 10);
      saved_err = err_s[0];
      hold = $urandom_range(3, 20);
      repeat (hold) @(posedge clk);
      #1;
      check("hold:done", 32'(done_s[0]), 1);
      check("hold:err",  32'(err_s[0]), saved_err);

      // Sum[0] stuck-at-0, started from DONE.
      fkind[0] = 1; fbit[0] = 0; fval[0] = 1'b0;
      run_and_verify(0, "sum0sa0", 513, 1, 10);
      check("sum0sa0:err256", 32'(err_s[0]), 256);
      check("sum0sa0:ffvec1", 32'(ffvec_s[0]), 1);

      // Random single faults.
      for (int t = 0; t < 3; t++) begin
         fkind[0] = $urandom_range(1, 2);
         fbit[0]  = $urandom_range(0, 4);
         fval[0]  = 1'($urandom_range(0, 1));
         run_and_verify(0, $sformatf("rand%0d_k%0d_b%0d_v%0d", t, fkind[0], fbit[0], fval[0]),
                        513, 1, 10);
      end

      // Cout inverted on the 8-bit counter: saturates at 255.
      fkind[1] = 2;
      run_and_verify(1, "coutinv", 513, 1, 8);
      check("coutinv:sat", 32'(err_s[1]), 255);
      // Restart from a failing DONE with a golden adder.
      fkind[1] = 0;
      run_and_verify(1, "rerun_golden", 513, 1, 8);

      // Registered adder: good with RESP_LAT=2, fails with RESP_LAT=1.
      regm[2] = 1'b1;
      run_and_verify(2, "reg_lat2", 514, 2, 10);
      fkind[0] = 0; regm[0] = 1'b1;
      run_and_verify(0, "reg_lat1", 513, 1, 10);
      check("reg_lat1:fails", 32'(pass_s[0]), 0);
      regm[0] = 1'b0;

      // Abort: start while busy is ignored, reset mid-run clears everything.
      fkind[0] = 1; fbit[0] = 0; fval[0] = 1'b0;
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("abort:vec100", 32'(stim_s[0]), 100);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      check("abort:vec101", 32'(stim_s[0]), 101);
      check("abort:busy",   32'(busy_s[0]), 1);
      repeat (199) @(posedge clk);
      #1;
      check("abort:vec300", 32'(stim_s[0]), 300);
      partial = 0;
      for (int k = 0; k < 300; k++) begin
         s = 10'((k >> 5) & 15) + 10'((k >> 1) & 15) + 10'(k & 1);
         if (s[0]) partial++;
      end
      check("abort:partial_err", 32'(err_s[0]), partial);
      rst_n = 1'b0;
      #1;
      check_reset_vals(0, "abort_rst");
      @(negedge clk) rst_n = 1'b1;
      fkind[0] = 0;
      @(posedge clk); #1;
      check("abort:idle_busy", 32'(busy_s[0]), 0);
      check("abort:idle_done", 32'(done_s[0]), 0);
      run_and_verify(0, "after_abort", 513, 1, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cla_bist_checker
`default_nettype wire
